flash_bus_ctl: RTL
==================

# flash_bus_ctl

Parametrised parallel flash/ROM bus controller for the NeoGS flash programmer, successor to the fixed 19-bit/8-bit controller. It takes byte-serial address loads and single-cycle read/write commands from the host-side command decoder, runs one externally-timed bus cycle per command with configurable setup/strobe/hold, and auto-increments the address. It adds a busy/done handshake and a hardware DQ7 data-polling mode for program-completion wait with timeout.

## Interface
- AW, 19: flash address width (1..32); NAB = ceil(AW/8) address bytes.
- DW, 8: flash data width (8 or 16); `wr_buffer`/`rd_buffer` width.
- SETUP_CYC, 1: cycles address/data stable before strobe (>=1).
- STROBE_CYC, 5: cycles `rom_cs_n` plus `rom_oe_n`/`rom_we_n` are low (>=1).
- HOLD_CYC, 1: cycles address/data held after strobe (>=1).
- POLL_MAX, 65535: maximum poll read cycles before timeout (>=1).

- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_addr  in  1  load next address byte from `wr_buffer[7:0]`.
- wr_data  in  1  write `wr_buffer` at next address.
- rd_data  in  1  read next address into `rd_buffer`.
- poll  in  1  DQ7-poll at last accessed address.
- wr_buffer  in  DW  command data/address byte.
- rd_buffer  out  DW  last read data.
- busy  out  1  bus cycle or poll sequence in progress.
- done  out  1  one-cycle pulse at end of each data/read/poll command.
- timeout  out  1  last poll exhausted POLL_MAX.
- rom_a  out  AW  flash address (tri-state).
- rom_d  inout  DW  flash data.
- rom_cs_n, rom_oe_n, rom_we_n  out  1  flash strobes.

## Operation
- Reset: strobes 1, `rom_d` and `rom_a` Z, `busy`/`done`/`timeout` 0, `rd_buffer` 0, next_addr 0, addr_phase byte 0, state IDLE. `rom_a` driven from the first edge after `rst` falls. Reset mid-cycle aborts immediately, same values.
- Commands sampled only in IDLE (`busy`=0); commands while busy ignored. More than one command strobe in one cycle: all ignored.
- `wr_addr`: writes byte `addr_phase` (0=LSB) of next_addr; top byte uses only low AW-8*(NAB-1) bits; addr_phase advances, NAB-1 wraps to 0. No bus cycle, no `done`.
- `wr_data`/`rd_data`/`poll` reset addr_phase to 0.
- `wr_data`/`rd_data`: output address register <= next_addr; next_addr <= next_addr+1 mod 2^AW (2^AW-1 -> 0); write latches `wr_buffer` as wrdata; run one bus cycle.
- `poll`: output address register unchanged; repeat read bus cycles until `rom_d[DW-1]` == wrdata[DW-1] (last written data), or POLL_MAX cycles done; next_addr unchanged.
- FSM: IDLE -> SETUP (SETUP_CYC) -> STROBE (STROBE_CYC) -> HOLD (HOLD_CYC) -> IDLE, or, in poll on mismatch with count<POLL_MAX, HOLD -> SETUP.
- SETUP: strobes high; write drives `rom_d`=wrdata. STROBE: `rom_cs_n`=0, `rom_we_n`=0 (write) or `rom_oe_n`=0 (read). HOLD: strobes high; write keeps driving `rom_d`. `rom_d` Z in IDLE and throughout reads.
- Read capture: `rd_buffer` <= `rom_d` at the edge ending the last STROBE cycle (every poll read too).
- `timeout`: cleared when any data/read/poll command is accepted; set at poll end on exhaustion; match ends with `timeout`=0.

## Timing
- Command at edge E: `busy`=1 and SETUP from E+1; all outputs registered.
- Single access: `busy` high exactly SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (defaults 7); strobe low exactly STROBE_CYC cycles.
- `done` high the first IDLE cycle (same edge `busy` falls); next command accepted that cycle.
- Poll of n reads: busy n*(S+T+H) cycles; match on read k ends after k reads.
- Address/data never change while a strobe is low.

## Test plan
- Reset mid-strobe during write -> strobes 1, `rom_d` Z, `busy` 0 same cycle as `rst` rise; after release `rom_a`=0.
- AW=19: `wr_addr` 0x56,0x34,0x07 then `rd_data`, flash model 0xA5 -> `rom_a`=0x73456, `oe_n` low 5 cycles, `rd_buffer`=0xA5, `done` after 7 busy cycles.
- Next_addr 0x7FFFF, two `rd_data` -> `rom_a` 0x7FFFF then 0x00000.
- `wr_data` 0x80, `poll`; model returns bit7=0 three reads then 1 -> 4 reads, `timeout`=0, `rom_a` unchanged.
- POLL_MAX=3, model never matches -> 3 reads, `timeout`=1, `done` pulse; next `rd_data` clears `timeout`.
- `rd_data` while busy, and `wr_data`+`rd_data` together in IDLE -> ignored, next_addr unchanged.

Source files
------------

// File: rtl/flash_bus_ctl.sv
// flash_bus_ctl: parametrised parallel flash/ROM bus controller with
// byte-serial address load, auto-increment and DQ7 program-completion polling.
module flash_bus_ctl #(
    parameter int AW         = 19,
    parameter int DW         = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 5,
    parameter int HOLD_CYC   = 1,
    parameter int POLL_MAX   = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_addr,
    input  logic          wr_data,
    input  logic          rd_data,
    input  logic          poll,
    input  logic [DW-1:0] wr_buffer,
    output logic [DW-1:0] rd_buffer,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [AW-1:0] rom_a,
    inout  wire  [DW-1:0] rom_d,
    output logic          rom_cs_n,
    output logic          rom_oe_n,
    output logic          rom_we_n
);
    localparam int NAB = (AW + 7) / 8;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t        state, state_d;
    logic [31:0]   cnt, pcnt;
    logic [AW-1:0] next_addr, addr_q;
    logic [DW-1:0] wrdata;
    logic [1:0]    phase;
    logic          a_en, wr_mode, poll_mode, last, mismatch, again, single, accept, load;

    // Simultaneous command strobes are treated as a malformed command and dropped.
    assign single   = $onehot({wr_addr, wr_data, rd_data, poll});
    assign load     = state == IDLE && single && wr_addr;
    assign accept   = state == IDLE && single && !wr_addr;
    assign last     = cnt == (state == SETUP  ? 32'(SETUP_CYC - 1) :
                              state == STROBE ? 32'(STROBE_CYC - 1) : 32'(HOLD_CYC - 1));
    assign mismatch = rd_buffer[DW-1] != wrdata[DW-1];
    assign again    = poll_mode && mismatch && pcnt + 1 < 32'(POLL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= state_d == state ? cnt + 1 : '0;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = last ? STROBE : SETUP;
            STROBE:  state_d = last ? HOLD : STROBE;
            HOLD:    state_d = last ? (again ? SETUP : IDLE) : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = state != IDLE;
        rom_cs_n = state != STROBE;
        rom_oe_n = !(state == STROBE && !wr_mode);
        rom_we_n = !(state == STROBE && wr_mode);
    end

    // Address bus stays floating until the first clock after reset release.
    assign rom_a = a_en ? addr_q : 'z;
    assign rom_d = (wr_mode && state != IDLE) ? wrdata : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_en      <= 1'b0;
            addr_q    <= '0;
            next_addr <= '0;
            phase     <= '0;
            wrdata    <= '0;
            rd_buffer <= '0;
            wr_mode   <= 1'b0;
            poll_mode <= 1'b0;
            pcnt      <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            a_en <= 1'b1;
            done <= state == HOLD && last && !again;
            if (load) begin
                for (int i = 0; i < AW; i++)
                    if (i / 8 == int'(phase)) next_addr[i] <= wr_buffer[i % 8];
                phase <= phase == 2'(NAB - 1) ? 2'd0 : phase + 2'd1;
            end
            if (accept) begin
                phase     <= '0;
                wr_mode   <= wr_data;
                poll_mode <= poll;
                pcnt      <= '0;
                timeout   <= 1'b0;
                if (!poll) begin
                    addr_q    <= next_addr;
                    next_addr <= next_addr + 1'b1;
                end
                if (wr_data) wrdata <= wr_buffer;
            end
            if (state == STROBE && last && !wr_mode) rd_buffer <= rom_d;
            if (state == HOLD && last) begin
                pcnt <= pcnt + 1;
                if (poll_mode && !again) timeout <= mismatch;
            end
        end
    end
endmodule
